// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable data width,
// optional even/odd parity and configurable stop length.
//
// Handshake: rx_done_tick is a one-clock pulse. dout, parity_err and
// frame_err all update on the same edge that raises it, and they hold
// until the next rx_done_tick. There is no back-pressure; a consumer must
// take the word in the pulse cycle or read the held value later.
module uart_rx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic [2:0]      dbg_state
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          PAR_EN  = (PARITY_EN != 0);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic [1:0]      rx_sync_q;
  logic            rx_s;

  assign rx_s = rx_sync_q[1];

  // Two-flop synchronizer on the asynchronous rx pin; it idles high.
  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], rx};
  end

  // Frame state, counters, shift register and held result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; only IDLE reacts without s_tick.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_HALF) begin
            // Still low at mid start bit: real start. High: a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = PAR_EN ? PARITY : STOP;
            else               n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            p_d     = rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            perr_d  = PAR_EN & ((^b_q ^ p_q) != PAR_ODD);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver; the next generation of the team's 8N1 `uart_rx`. It adds configurable data width, an optional even/odd parity bit and a configurable stop length. It also adds an input synchronizer, start-bit glitch rejection, and parity/framing error flags. It sits between the pin-side `rx` line and the RX FIFO/interface logic, and is paced by the shared baud-rate generator's oversampling tick `s_tick`.

Parameters:
DBIT, 8, data bits per frame (legal 5..9), LSB first
OVS, 16, oversampling ticks per bit (even, >=4)
SB_TICK, 16, ticks spent in stop state (16=1 stop, 24=1.5, 32=2 at OVS=16)
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high; one clock; clears all state
rx  in  1  serial input, idle high, asynchronous to clk
s_tick  in  1  oversampling enable, one clk wide, OVS per bit period
rx_done_tick  out  1  one-cycle pulse: frame complete, outputs valid
dout  out  DBIT  received data word, bit0 = first data bit on line
parity_err  out  1  last frame's parity mismatched (0 when PARITY_EN=0)
frame_err  out  1  last frame's stop bit sampled low

Behaviour:
- Reset values: state=IDLE, tick count s=0, bit count n=0, shift reg=0, dout=0, rx_done_tick=0, parity_err=0, frame_err=0, sync flops=1.
- Input synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s, so there is a 2-clk input latency.
- IDLE: rx_s==0 -> START with s=0. s_tick is not required to leave IDLE.
- All other state actions occur only in cycles with s_tick=1; without s_tick, state and counters hold.
- START: at s==OVS/2-1, if rx_s==0 go to DATA with s=0, n=0. If rx_s==1, treat it as a glitch: return to IDLE with no flags changed. Otherwise s++.
- DATA: at s==OVS-1, set s=0 and shift right with rx_s into the MSB of the DBIT-wide register.
  - If n==DBIT-1: go to PARITY when PARITY_EN, else STOP.
  - Otherwise n++.
  - Otherwise (s != OVS-1) s++.
- PARITY: at s==OVS-1, capture p=rx_s, set s=0, go to STOP.
- STOP: at s==SB_TICK-1, do all of the following in the next clock edge, then go to IDLE:
  - load dout from the shift register;
  - set frame_err = ~rx_s;
  - set parity_err = PARITY_EN & ((^data ^ p) != PARITY_ODD);
  - pulse rx_done_tick.
- Error behaviour:
  - A frame with errors still delivers dout and rx_done_tick.
  - parity_err and frame_err stay valid and held until the next rx_done_tick updates them.
- Return to IDLE is immediate. A new start bit is accepted from the clock after STOP completes.
- s_tick tied high is legal: every clk is a tick.
- Reset mid-frame aborts the frame immediately: no rx_done_tick, dout=0, flags cleared. After release, the first low on rx_s starts a new frame.
- A line held low (break) produces a frame of all zeros with frame_err=1, then re-enters START on the next clock while rx_s is still low.
- Counter widths: s wide enough for max(OVS, SB_TICK)-1; n wide enough for DBIT-1. No wrap occurs inside a state.

Test Plan:
- Defaults, s_tick every clk, send 0xA5 8N1 (16 clks/bit) -> exactly one rx_done_tick, dout=8'hA5, parity_err=0, frame_err=0, pulse 1 clk wide.
- PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 0, then 0x03 with parity bit 1 -> dout=8'h03 both times; parity_err=0 then 1.
- DBIT=7, PARITY_EN=1, PARITY_ODD=1, SB_TICK=32, s_tick every 4th clk, send 7'h41 with parity 1 -> dout=7'h41, no errors, done pulse after 2 stop bit periods.
- Defaults, send 0x5A with stop bit driven 0 -> rx_done_tick, dout=8'h5A, frame_err=1. Next valid frame 0x11 -> frame_err returns to 0.
- Glitch: rx low for 4 ticks, then high -> FSM returns to IDLE, no rx_done_tick. A following 0xFF frame is received correctly.
- Assert reset for 1 clk during data bit 3 of a frame -> no rx_done_tick, dout=0, flags 0. The next full frame 0x3C is received correctly.
